// File: rtl/bp_btb_pkg.sv
// ============================================================================
// Module : bp_btb_pkg
// Brief  : Shared constants and update-action encoding for the branch target
//          buffer and its saturating direction counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_btb_pkg;

  localparam int BTB_ENTRIES_DEF = 16;
  localparam int BTB_TAG_W_DEF   = 8;
  localparam int BTB_CNT_W_DEF   = 2;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_INC   = 2'd1,
    UPD_DEC   = 2'd2,
    UPD_ALLOC = 2'd3
  } btb_upd_e;

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// Module : bp_sat_counter
// Brief  : Next-value logic for one CNT_W-bit saturating up/down counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_sat_counter #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i && (cnt_i != {CNT_W{1'b1}})) begin
      cnt_o = cnt_i + CNT_W'(1);
    end else if (dec_i && (cnt_i != '0)) begin
      cnt_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_btb.sv
// ============================================================================
// Module : bp_btb
// Brief  : Direct-mapped branch target buffer with saturating direction
//          counters, zero-latency lookup and a misprediction counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_btb
  import bp_btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES_DEF,
  parameter int TAG_W   = BTB_TAG_W_DEF,
  parameter int CNT_W   = BTB_CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispred_i,
  input  logic        flush_i,
  output logic [31:0] mispred_cnt_o
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + 1 + TAG_W;
  localparam logic [CNT_W-1:0] C_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] C_WEAK_NT = C_WEAK_T - CNT_W'(1);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];
  logic [CNT_W-1:0]   cnt_nxt  [ENTRIES];
  logic [31:0]        mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  btb_upd_e         upd_act;

  assign lk_idx  = pc_i[TAG_LO-1:2];
  assign lk_tag  = pc_i[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc_i[TAG_LO-1:2];
  assign upd_tag = upd_pc_i[TAG_HI:TAG_LO];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = pred_hit_o && cnt_q[lk_idx][CNT_W-1];
  assign pred_target_o = pred_hit_o ? target_q[lk_idx] : 32'h0;
  assign mispred_cnt_o = mispred_cnt_q;

  logic unused_pc_lo;
  assign unused_pc_lo = ^{pc_i[1:0], upd_pc_i[1:0]};

  generate
    if (TAG_HI < 31) begin : g_unused_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^{pc_i[31:TAG_HI+1], upd_pc_i[31:TAG_HI+1]};
    end
  endgenerate

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_act = UPD_NONE;
    if (upd_valid_i) begin
      if (upd_hit) begin
        upd_act = upd_taken_i ? UPD_INC : UPD_DEC;
      end else if (upd_taken_i) begin
        upd_act = UPD_ALLOC;
      end
    end
  end

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
      logic sel;
      assign sel = (upd_idx == IDX_W'(i));
      bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt_i (cnt_q[i]),
        .inc_i (sel && (upd_act == UPD_INC)),
        .dec_i (sel && (upd_act == UPD_DEC)),
        .cnt_o (cnt_nxt[i])
      );
    end
  endgenerate

  // Flush only clears valid bits and takes priority over any update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      valid_d = '0;
    end else begin
      case (upd_act)
        UPD_INC: begin
          cnt_d[upd_idx]    = cnt_nxt[upd_idx];
          target_d[upd_idx] = upd_target_i;
        end
        UPD_DEC: cnt_d[upd_idx] = cnt_nxt[upd_idx];
        UPD_ALLOC: begin
          valid_d[upd_idx]  = 1'b1;
          tag_d[upd_idx]    = upd_tag;
          target_d[upd_idx] = upd_target_i;
          cnt_d[upd_idx]    = C_WEAK_T;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (upd_valid_i && upd_mispred_i && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= C_WEAK_NT;
      end
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      cnt_q         <= cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bp_btb.sv
// ============================================================================
// Module : tb_bp_btb
// Brief  : Directed self-checking bench for bp_btb at default parameters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_btb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h100;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o, mispred_cnt_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_mispred_i = 1'b0;
  logic        flush_i = 1'b0;

  int total = 0;
  int bad   = 0;

  bp_btb dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pred_hit_o    (pred_hit_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .upd_mispred_i (upd_mispred_i),
    .flush_i       (flush_i),
    .mispred_cnt_o (mispred_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic look(input string name, input logic [31:0] pc,
                      input logic hit, input logic taken, input logic [31:0] tgt);
    pc_i = pc;
    #1;
    check({name, "_hit"},    {31'd0, pred_hit_o},   {31'd0, hit});
    check({name, "_taken"},  {31'd0, pred_taken_o}, {31'd0, taken});
    check({name, "_target"}, pred_target_o,         tgt);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic mis);
    upd_valid_i   = 1'b1;
    upd_pc_i      = pc;
    upd_taken_i   = taken;
    upd_target_i  = tgt;
    upd_mispred_i = mis;
    step();
    upd_valid_i   = 1'b0;
    upd_mispred_i = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    look("rst", 32'h100, 1'b0, 1'b0, 32'h0);
    check("rst_mcnt", mispred_cnt_o, 32'h0);
    rst = 1'b0;
    step();

    // Allocate at 0x100 (idx 0, tag 4); 0x140 aliases idx 0 with tag 5
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    look("alias", 32'h140, 1'b0, 1'b0, 32'h0);

    // Counter 10 -> 01 -> 00 -> 00, target retained
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("dec1", 32'h100, 1'b1, 1'b0, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("dec3", 32'h100, 1'b1, 1'b0, 32'h200);

    // Same-cycle update + lookup: outputs reflect pre-update entry (cnt 00)
    pc_i = 32'h100;
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h100;
    upd_taken_i  = 1'b1;
    upd_target_i = 32'h300;
    #1;
    check("byp_taken",  {31'd0, pred_taken_o}, 32'd0);
    check("byp_target", pred_target_o, 32'h200);
    step();
    upd_valid_i = 1'b0;
    look("post_inc1", 32'h100, 1'b1, 1'b0, 32'h300);

    // 01 -> 10 -> 11 -> 11, then 10 (still taken), then 01
    upd(32'h100, 1'b1, 32'h300, 1'b0);
    look("inc2", 32'h100, 1'b1, 1'b1, 32'h300);
    upd(32'h100, 1'b1, 32'h304, 1'b0);
    upd(32'h100, 1'b1, 32'h308, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h308);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("back_nt", 32'h100, 1'b1, 1'b0, 32'h308);

    // Miss+taken overwrites direct-mapped slot; miss+not-taken changes nothing
    upd(32'h140, 1'b1, 32'h500, 1'b0);
    look("ovw_new", 32'h140, 1'b1, 1'b1, 32'h500);
    look("ovw_old", 32'h100, 1'b0, 1'b0, 32'h0);
    upd(32'h104, 1'b0, 32'h600, 1'b0);
    look("miss_nt", 32'h104, 1'b0, 1'b0, 32'h0);

    // Flush with a concurrent mispredicting update: flush wins, count still bumps
    flush_i = 1'b1;
    upd(32'h108, 1'b1, 32'h700, 1'b1);
    flush_i = 1'b0;
    look("flush_a", 32'h140, 1'b0, 1'b0, 32'h0);
    look("flush_b", 32'h108, 1'b0, 1'b0, 32'h0);
    check("flush_mcnt", mispred_cnt_o, 32'd1);

    // Counter saturation near the top
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt_q;
    @(negedge clk);
    upd(32'h10C, 1'b0, 32'h0, 1'b1);
    check("mcnt_max", mispred_cnt_o, 32'hFFFF_FFFF);
    upd(32'h10C, 1'b0, 32'h0, 1'b1);
    check("mcnt_hold", mispred_cnt_o, 32'hFFFF_FFFF);

    // Async reset mid-operation with a pending update
    upd(32'h100, 1'b1, 32'h800, 1'b1);
    look("pre_rst", 32'h100, 1'b1, 1'b1, 32'h800);
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h100;
    upd_taken_i   = 1'b1;
    upd_mispred_i = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("arst_mcnt", mispred_cnt_o, 32'h0);
    look("arst", 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    upd_valid_i   = 1'b0;
    upd_mispred_i = 1'b0;
    rst = 1'b0;
    step();
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h0);
    check("post_rst_mcnt", mispred_cnt_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
